// File: rtl/div_sequencer.sv
// Restoring DIV/DIVU/REM/REMU sequencer driving one external adder; 37 cycles start->valid, 1 for div-by-zero/overflow.
// No backpressure: start is ignored while busy; kill or rst abandons the operation without a valid pulse.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             kill,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] adder_x,
    output logic [WIDTH-1:0] adder_y,
    output logic             adder_sub,
    input  logic [WIDTH-1:0] adder_result,
    input  logic             adder_cout
);

    typedef enum logic [2:0] {
        S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_FIX_Q, S_FIX_R, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    logic               accept, div_zero, div_ovf, neg_q, ge;
    logic [WIDTH-1:0]   r_shift, r_fix;

    assign accept   = start && !kill;
    assign div_zero = (divisor == '0);
    assign div_ovf  = !op[0] && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    assign neg_q    = neg_a_q ^ neg_b_q;
    assign r_shift  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    // Trial subtraction succeeds when the shifted-out bit was set or Rs >= B (no borrow).
    assign ge       = r_q[WIDTH-1] | adder_cout;
    assign r_fix    = neg_a_q ? adder_result : r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (div_zero || div_ovf) ? S_DONE : S_ABS_A;
            S_ABS_A: state_d = S_ABS_B;
            S_ABS_B: state_d = S_ITER;
            S_ITER:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX_Q;
            S_FIX_Q: state_d = S_FIX_R;
            S_FIX_R: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        valid     = (state_q == S_DONE);
        adder_x   = '0;
        adder_y   = '0;
        adder_sub = 1'b0;
        case (state_q)
            S_ABS_A: if (neg_a_q) begin adder_x = ~a_q; adder_sub = 1'b1; end
            S_ABS_B: if (neg_b_q) begin adder_x = ~b_q; adder_sub = 1'b1; end
            S_ITER:  begin adder_x = r_shift; adder_y = ~b_q; adder_sub = 1'b1; end
            S_FIX_Q: if (neg_q) begin adder_x = ~q_q; adder_sub = 1'b1; end
            S_FIX_R: if (neg_a_q) begin adder_x = ~r_q; adder_sub = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        q_d      = q_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op;
                    a_d     = dividend;
                    b_d     = divisor;
                    neg_a_d = !op[0] && dividend[WIDTH-1];
                    neg_b_d = !op[0] && divisor[WIDTH-1];
                    if (div_zero) begin
                        q_d      = '1;
                        r_d      = dividend;
                        result_d = op[1] ? dividend : '1;
                    end else if (div_ovf) begin
                        q_d      = {1'b1, {(WIDTH-1){1'b0}}};
                        r_d      = '0;
                        result_d = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                    end
                end
            end
            S_ABS_A: if (neg_a_q) a_d = adder_result;
            S_ABS_B: begin
                b_d   = neg_b_q ? adder_result : b_q;
                r_d   = '0;
                q_d   = a_q;
                cnt_d = '0;
            end
            S_ITER: begin
                r_d   = ge ? adder_result : r_shift;
                q_d   = {q_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIX_Q: if (neg_q) q_d = adder_result;
            S_FIX_R: begin
                r_d      = r_fix;
                result_d = op_q[1] ? r_fix : q_q;
            end
            default: ;
        endcase
        if (kill && state_q != S_IDLE) result_d = result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            q_q      <= q_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed RISC-V divide cases plus randomized operands against an arithmetic reference.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy, valid, adder_sub, adder_cout;
    logic [31:0] result, adder_x, adder_y, adder_result;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_result = 32'd0;

    always #5 clk = ~clk;

    // Behavioural carry-lookahead adder stand-in: x + y + sub with carry-out.
    assign {adder_cout, adder_result} = {1'b0, adder_x} + {1'b0, adder_y} + {32'd0, adder_sub};

    div_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .kill(kill),
        .busy(busy), .valid(valid), .result(result),
        .adder_x(adder_x), .adder_y(adder_y), .adder_sub(adder_sub),
        .adder_result(adder_result), .adder_cout(adder_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            sa = $signed(a);
            sb = $signed(b);
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    // Issues one operation and watches 40 cycles; n counts clock edges since start was sampled.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int kill_at, input int rst_at, input int busy_start_at);
        bit          sgn, special, aborted, iter_ok, busy_ok, done_adder_ok;
        int          abort_at, exp_lat, lat, pulses;
        logic [31:0] abs_b, res_at_valid;
        sgn      = !o[0];
        special  = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp_lat  = special ? 1 : 37;
        abs_b    = (sgn && b[31]) ? -b : b;
        abort_at = (kill_at > 0) ? kill_at : rst_at;
        aborted  = (abort_at > 0);
        op = o; dividend = a; divisor = b; start = 1'b1;
        lat = 0; pulses = 0; res_at_valid = 32'd0;
        iter_ok = 1'b1; busy_ok = 1'b1; done_adder_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = n;
                    res_at_valid = result;
                end
                if (adder_x !== 32'd0 || adder_y !== 32'd0 || adder_sub !== 1'b0) done_adder_ok = 1'b0;
            end
            if (!aborted) begin
                if (!special && n >= 3 && n <= 34 && (adder_y !== ~abs_b || adder_sub !== 1'b1)) iter_ok = 1'b0;
                if (busy !== (n <= exp_lat)) busy_ok = 1'b0;
            end else if (busy !== (n <= abort_at)) begin
                busy_ok = 1'b0;
            end
            start = (n == busy_start_at);
            if (start) begin
                op = 2'($urandom_range(0, 3));
                dividend = $urandom;
                divisor = $urandom;
            end
            kill = (n == kill_at);
            rst  = (n == rst_at);
        end
        if (aborted) begin
            check({tag, " valid pulses"}, 32'(pulses), 32'd0);
            check({tag, " busy profile"}, {31'd0, busy_ok}, 32'd1);
            if (rst_at > 0) last_result = 32'd0;
            check({tag, " result held"}, result, last_result);
        end else begin
            check({tag, " latency"}, 32'(lat), 32'(exp_lat));
            check({tag, " valid pulses"}, 32'(pulses), 32'd1);
            check({tag, " result"}, res_at_valid, exp_res);
            check({tag, " result held"}, result, exp_res);
            check({tag, " busy profile"}, {31'd0, busy_ok}, 32'd1);
            check({tag, " done adder idle"}, {31'd0, done_adder_ok}, 32'd1);
            if (!special) check({tag, " iter adder drive"}, {31'd0, iter_ok}, 32'd1);
            last_result = exp_res;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        int          pulses;

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset adder_x", adder_x, 32'd0);
        check("reset adder_y", adder_y, 32'd0);
        check("reset adder_sub", {31'd0, adder_sub}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu 100/7",    2'b01, 32'd100,        32'd7,          32'd14,         0, 0, 5);
        run_op("rem -7/2",      2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0, 0, 0);
        run_op("div -7/2",      2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0, 0, 0);
        run_op("divu max/1",    2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  0, 0, 0);
        run_op("remu msb",      2'b11, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  0, 0, 0);
        run_op("divu 5/0",      2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  0, 0, 0);
        run_op("remu 5/0",      2'b11, 32'd5,          32'd0,          32'd5,          0, 0, 0);
        run_op("div -3/0",      2'b00, 32'hFFFF_FFFD,  32'd0,          32'hFFFF_FFFF,  0, 0, 0);
        run_op("div overflow",  2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0, 0, 0);
        run_op("rem overflow",  2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, 0, 0);
        run_op("div 100/-9",    2'b00, 32'd100,        32'hFFFF_FFF7,  32'hFFFF_FFF5,  0, 0, 0);
        run_op("kill iter",     2'b01, 32'd1000,       32'd3,          32'd0,          10, 0, 0);

        // start with kill in IDLE must not launch anything
        op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("start+kill busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid || busy) pulses++;
        end
        check("start+kill activity", 32'(pulses), 32'd0);
        check("start+kill result", result, last_result);

        run_op("rst mid-op",    2'b00, 32'd12345,      32'hFFFF_FFF9,  32'd0,          0, 20, 0);
        run_op("divu 9/3",      2'b01, 32'd9,          32'd3,          32'd3,          0, 0, 0);

        for (int i = 0; i < 120; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = 32'($urandom_range(1, 20)); end
                2: begin ra = $urandom; rb = 32'd0; end
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: begin
                    ra = 32'($urandom_range(0, 1000));
                    rb = 32'($urandom_range(1, 50));
                    if ($urandom_range(0, 1) == 1) ra = -ra;
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                default: begin ra = $urandom; rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
            endcase
            run_op("random", ro, ra, rb, ref_div(ro, ra, rb), 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller for the M-extension DIV/DIVU/REM/REMU instructions in the EX stage.
- Owns no adder. It sequences one external 32-bit carry-lookahead adder with restoring division: one adder operation per cycle for operand absolute values, 32 trial subtractions and sign fix-up.
- The adder computes x + y + sub and exposes carry-out. It does NOT invert y, so the sequencer drives y = ~operand with sub=1 to subtract.
- Pipeline stalls EX while busy=1.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  32  rs1 value, sampled with start
- divisor  input  32  rs2 value, sampled with start
- kill  input  1  pipeline flush; aborts the operation
- busy  output  1  high from the cycle after start through the DONE cycle
- valid  output  1  one-cycle pulse, result valid
- result  output  32  quotient or remainder per op; held until the next accepted start
- adder_x  output  32  adder operand x
- adder_y  output  32  adder operand y
- adder_sub  output  1  adder carry-in
- adder_result  input  32  adder sum, combinational from adder_x/adder_y/adder_sub
- adder_cout  input  1  adder carry-out

Behaviour:
- Reset: state=IDLE; busy=0, valid=0, result=0. Internal A, B, Q, R and counter are cleared.
- Adder drive: adder_x, adder_y and adder_sub are decoded combinationally from state. In IDLE and DONE all three are 0.
- States: IDLE, ABS_A, ABS_B, ITER, FIX_Q, FIX_R, DONE.
- IDLE, start=1, kill=0: latch op, dividend, divisor. Then:
  - divisor==0: Q=32'hFFFFFFFF, R=dividend; next state DONE.
  - Signed op, dividend==32'h80000000, divisor==32'hFFFFFFFF: Q=32'h80000000, R=0; next state DONE.
  - Otherwise next state ABS_A.
- ABS_A: if signed and dividend[31], adder_x=~A, y=0, sub=1, and A<=adder_result; else A unchanged. Next state ABS_B.
- ABS_B: same rule applied to B. R<=0, Q<=A, cnt<=0. Next state ITER.
- ITER, per cycle:
  - msb=R[31]; Rs={R[30:0],Q[31]}.
  - Adder drive: adder_x=Rs, adder_y=~B, sub=1.
  - ge=msb|adder_cout.
  - R<= ge ? adder_result : Rs; Q<={Q[30:0],ge}; cnt<=cnt+1.
  - After 32 cycles (cnt==31), next state FIX_Q.
- FIX_Q: negate Q via the adder (x=~Q, y=0, sub=1) if signed and dividend[31]^divisor[31]; else hold. Next state FIX_R.
- FIX_R: negate R the same way if signed and dividend[31]; else hold. Next state DONE.
- DONE:
  - valid=1 for exactly this cycle.
  - result<= op[1] ? R : Q, registered so it is visible in the DONE cycle.
  - Next state IDLE.
- busy: 1 in every state except IDLE.
- Latency:
  - Normal path: start sampled at cycle t; valid at t+37 (ABS_A t+1, ABS_B t+2, ITER t+3..t+34, FIX_Q t+35, FIX_R t+36, DONE t+37).
  - Special cases (divide by zero, signed overflow): valid at t+1.
- Back-to-back: start is ignored while busy=1. The cycle after DONE is IDLE, so a new start can be accepted at t+38.
- kill:
  - In any non-IDLE state, kill=1 forces IDLE on the next edge. No valid pulse; result is unchanged.
  - In IDLE, kill=1 with start=1: kill wins and start is dropped.
- rst mid-operation: returns to the reset values on the next edge; no valid.
- Division arithmetic is unsigned on |A|, |B|, truncating toward zero. The remainder takes the dividend's sign, per RISC-V.

Test Plan:
- DIVU 100/7: start at t -> valid=1 only at t+37, result=14; adder_y=~7 and adder_sub=1 throughout ITER.
- REM -7/2 (32'hFFFFFFF9, 2) -> result=32'hFFFFFFFF; DIV same operands -> result=32'hFFFFFFFD; both valid at t+37.
- DIVU 32'hFFFFFFFF/1 -> 32'hFFFFFFFF; REMU 32'hFFFFFFFE/32'hFFFFFFFF -> 32'hFFFFFFFE (exercises msb=1 path).
- Divide by zero: DIVU 5/0 -> 32'hFFFFFFFF, REMU 5/0 -> 5, DIV -3/0 -> 32'hFFFFFFFF; each valid at t+1, busy high one cycle. Overflow: DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000, REM -> 0, valid at t+1.
- kill at t+10 during ITER -> IDLE at t+11, busy=0, no valid ever, result keeps its prior value. A start asserted at t+5 while busy -> ignored. Start and kill together in IDLE -> no operation.
- rst asserted at t+20 -> busy=0, valid=0, result=0 next cycle. A fresh DIVU 9/3 afterwards -> result=3 at its t+37.
